// File: rtl/tt_um_mauriceasic_sum_checker.sv
// Initiator for the pin-level adder link: drives operand A, reads the partner's sum back
// and counts mismatches against A + OPERAND_B over a run of counter or LFSR vectors.
module tt_um_mauriceasic_sum_checker #(
  parameter logic [7:0]  OPERAND_B     = 8'h35,
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned VecW = 10;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrive  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [3:0]      ctl_s1_q, ctl_s2_q;
  logic [7:0]      sum_s1_q, sum_s2_q;
  logic            start_prev_q;
  logic [2:0]      state_q, state_d;
  logic            mode_q, mode_d;
  logic [7:0]      op_q, op_d;
  logic [VecW-1:0] vec_q, vec_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      uo_q, uo_d;
  logic [3:0]      status_q, status_d;

  logic       start_rise, abort_s, show_s, busy, busy_d, done_d;
  logic [7:0] sum_exp;
  logic       unused;

  assign unused     = &{1'b0, ena, uio_in[7:4]};
  assign start_rise = ctl_s2_q[0] & ~start_prev_q;
  assign abort_s    = ctl_s2_q[2];
  assign show_s     = ctl_s2_q[3];
  assign busy       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
  assign sum_exp    = op_q + OPERAND_B;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    op_d    = op_q;
    vec_d   = vec_q;
    err_d   = err_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    // Abort wins over everything else a busy state might do this cycle.
    if (busy && abort_s) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_rise && !abort_s) begin
            state_d = StDrive;
            mode_d  = ctl_s2_q[1];
            err_d   = 8'h00;
            vec_d   = '0;
            lfsr_d  = 8'h01;
          end
        end
        StDrive: begin
          op_d    = mode_q ? lfsr_q : vec_q[7:0];
          cnt_d   = '0;
          state_d = StSettle;
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCheck: begin
          if ((sum_s2_q != sum_exp) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
          vec_d   = vec_q + 1'b1;
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          state_d = (vec_d == VecW'(NUM_VECTORS)) ? StDone : StDrive;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are computed from next-state values so every pin comes straight off a flop.
  always_comb begin
    busy_d   = (state_d == StDrive) || (state_d == StSettle) || (state_d == StCheck);
    done_d   = (state_d == StDone);
    uo_d     = (!busy_d && show_s) ? err_d : op_d;
    status_d = {err_d != 8'h00, done_d && (err_d == 8'h00), done_d, busy_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_s1_q     <= '0;
      ctl_s2_q     <= '0;
      sum_s1_q     <= '0;
      sum_s2_q     <= '0;
      start_prev_q <= 1'b0;
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      op_q         <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      lfsr_q       <= 8'h01;
      cnt_q        <= '0;
      uo_q         <= '0;
      status_q     <= '0;
    end else begin
      ctl_s1_q     <= uio_in[3:0];
      ctl_s2_q     <= ctl_s1_q;
      sum_s1_q     <= ui_in;
      sum_s2_q     <= sum_s1_q;
      start_prev_q <= ctl_s2_q[0];
      state_q      <= state_d;
      mode_q       <= mode_d;
      op_q         <= op_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      uo_q         <= uo_d;
      status_q     <= status_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {status_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule
